// File: rtl/ce_gen_pkg.sv
// Shared types and default ratios for the clock-enable generator.
// Default ratios are relative to a 50 MHz system clock.
package ce_gen_pkg;

    localparam int CE_DIV_W = 16;

    typedef struct packed {
        logic [CE_DIV_W-1:0] num;
        logic [CE_DIV_W-1:0] den;
    } ratio_t;

    // 50 MHz * 4/5 = 40 MHz
    localparam ratio_t CE_R_40M = '{num: 16'd4, den: 16'd5};
    // 50 MHz * 1/5 = 10 MHz
    localparam ratio_t CE_R_10M = '{num: 16'd1, den: 16'd5};
    // 50 MHz * 2/25 = 4 MHz
    localparam ratio_t CE_R_4M  = '{num: 16'd2, den: 16'd25};

endpackage

// File: rtl/ce_gen_chan.sv
// One fractional-rate enable channel: accumulate num, wrap at den.
// Emits exactly num registered pulses every den cycles while running.
module ce_gen_chan
    import ce_gen_pkg::*;
#(
    parameter int DIV_W = CE_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] num,
    input  logic [DIV_W-1:0] den,
    output logic             ce
);

    logic [DIV_W:0] acc;
    logic [DIV_W:0] sum;
    logic           hit;
    logic           off;
    logic           full;

    // Next accumulator sum and ratio classification
    always_comb begin
        sum  = acc + {1'b0, num};
        hit  = (sum >= {1'b0, den});
        off  = (num == '0) || (den == '0);
        full = (num >= den);
    end

    // Accumulator and pulse register; num>=den pins acc at 0 to avoid growth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (clr || !run || off) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (full) begin
            acc <= '0;
            ce  <= 1'b1;
        end else if (hit) begin
            acc <= sum - {1'b0, den};
            ce  <= 1'b1;
        end else begin
            acc <= sum;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/ce_gen_multi.sv
// Multi-channel programmable clock-enable generator with lock indication.
// Optional phase re-align input sync_i is built when CEGEN_SYNC_EN is defined.
module ce_gen_multi
    import ce_gen_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = CE_DIV_W,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*DIV_W-1:0] INIT_NUM =
        {CE_R_4M.num, CE_R_10M.num, CE_R_40M.num},
    parameter logic [NUM_CH*DIV_W-1:0] INIT_DEN =
        {CE_R_4M.den, CE_R_10M.den, CE_R_40M.den},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_num,
    input  logic [DIV_W-1:0]  cfg_den,
`ifdef CEGEN_SYNC_EN
    input  logic              sync_i,
`endif
    output logic [NUM_CH-1:0] ce_o,
    output logic              locked
);

    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_CYCLES - 1);

    logic [DIV_W-1:0] num_q [NUM_CH];
    logic [DIV_W-1:0] den_q [NUM_CH];
    logic [LC_W-1:0]  lock_cnt;
    logic             wr_ok;
    logic             sync_hit;
    logic             clr;

    // Decode a valid write and the phase-clear request
    always_comb begin
        wr_ok = cfg_wr && (int'(cfg_ch) < NUM_CH);
`ifdef CEGEN_SYNC_EN
        sync_hit = sync_i && locked;
`else
        sync_hit = 1'b0;
`endif
        clr = wr_ok || sync_hit;
    end

    // Per-channel ratio register file; only the addressed channel changes
    always_ff @(posedge refclk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rst_n) begin
                num_q[k] <= INIT_NUM[k*DIV_W +: DIV_W];
                den_q[k] <= INIT_DEN[k*DIV_W +: DIV_W];
            end else if (wr_ok && (cfg_ch == CH_W'(k))) begin
                num_q[k] <= cfg_num;
                den_q[k] <= cfg_den;
            end
        end
    end

    // Lock counter; any valid write restarts the settle window
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (wr_ok) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            if (lock_cnt == LC_LAST) begin
                locked <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ce_gen_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk  (refclk),
            .rst_n(rst_n),
            .run  (locked),
            .clr  (clr),
            .num  (num_q[k]),
            .den  (den_q[k]),
            .ce   (ce_o[k])
        );
    end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Self-checking bench for ce_gen_multi: per-cycle reference model
// plus directed pulse-count and pattern checks and random reprogramming.
module tb_ce_gen_multi;

    localparam int NCH = 3;
    localparam int L   = 16;

    logic        refclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_num = '0;
    logic [15:0] cfg_den = '0;
`ifdef CEGEN_SYNC_EN
    logic        sync_i = 1'b0;
`endif
    logic [2:0]  ce_o;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int nstep  = 0;

    int since = 0;
    int t     = 0;
    int mnum [NCH];
    int mden [NCH];
    int pc   [NCH];

    always #5 refclk = ~refclk;

    ce_gen_multi dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .cfg_wr (cfg_wr),
        .cfg_ch (cfg_ch),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
`ifdef CEGEN_SYNC_EN
        .sync_i (sync_i),
`endif
        .ce_o   (ce_o),
        .locked (locked)
    );

    task automatic init_ratios();
        mnum[0] = 4;  mden[0] = 5;
        mnum[1] = 1;  mden[1] = 5;
        mnum[2] = 2;  mden[2] = 25;
    endtask

    // Pulse k fires at locked cycle tt iff floor(tt*n/d) steps up
    function automatic logic model_ce(int k, int tt);
        longint n = mnum[k];
        longint d = mden[k];
        if (tt <= 0 || n == 0 || d == 0) return 1'b0;
        if (n >= d) return 1'b1;
        return ((tt * n) / d) != (((tt - 1) * n) / d);
    endfunction

    task automatic clr_pc();
        for (int k = 0; k < NCH; k++) pc[k] = 0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input int ch,
                        input int n, input int d, input logic sy);
        logic       was_lk;
        logic       sy_eff;
        logic [2:0] exp_ce;
        logic       exp_lk;
        rst_n   = ~rst;
        cfg_wr  = wr;
        cfg_ch  = 2'(ch);
        cfg_num = 16'(n);
        cfg_den = 16'(d);
`ifdef CEGEN_SYNC_EN
        sync_i  = sy;
        sy_eff  = sy;
`else
        sy_eff  = sy & 1'b0;
`endif
        @(posedge refclk);
        nstep++;
        was_lk = (since >= L);
        if (rst) begin
            since = 0;
            t     = 0;
            init_ratios();
        end else if (wr && ch < NCH) begin
            since    = 0;
            t        = 0;
            mnum[ch] = n;
            mden[ch] = d;
        end else begin
            since++;
            if (was_lk && sy_eff) t = 0;
            else if (was_lk) t++;
        end
        exp_lk = (since >= L);
        for (int k = 0; k < NCH; k++) exp_ce[k] = model_ce(k, t);
        #1;
        checks++;
        assert (locked === exp_lk) else begin
            errors++;
            $error("FAIL locked step %0d got %b exp %b", nstep, locked, exp_lk);
        end
        checks++;
        assert (ce_o === exp_ce) else begin
            errors++;
            $error("FAIL ce_o step %0d got %b exp %b", nstep, ce_o, exp_ce);
        end
        for (int k = 0; k < NCH; k++) pc[k] += int'(ce_o[k]);
        cfg_wr = 1'b0;
        rst_n  = 1'b1;
`ifdef CEGEN_SYNC_EN
        sync_i = 1'b0;
`endif
    endtask

    task automatic idle(input int cyc);
        for (int i = 0; i < cyc; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int pat [5];
        int seen;
        pat = '{0, 1, 1, 1, 1};
        init_ratios();

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_ce", int'(ce_o), 0);

        // Lock timing and default rates
        clr_pc();
        idle(15);
        chk("lock_15", int'(locked), 0);
        idle(1);
        chk("lock_16", int'(locked), 1);
        chk("no_early_pulse", pc[0] + pc[1] + pc[2], 0);
        clr_pc();
        idle(250);
        chk("cnt250_ch0", pc[0], 200);
        chk("cnt250_ch1", pc[1], 50);
        chk("cnt250_ch2", pc[2], 20);

        // Channel 2 at 4/5: 0,1,1,1,1 repeating
        step(1'b0, 1'b1, 2, 4, 5, 1'b0);
        chk("wr_unlock", int'(locked), 0);
        idle(16);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("pat45_ch2", int'(ce_o[2]), pat[i % 5]);
        end

        // Channel 1 at 3/7 mid-run
        step(1'b0, 1'b1, 1, 3, 7, 1'b0);
        chk("wr37_locked", int'(locked), 0);
        chk("wr37_ce", int'(ce_o), 0);
        idle(16);
        chk("relock37", int'(locked), 1);
        clr_pc();
        idle(70);
        chk("cnt70_ch1", pc[1], 30);
        chk("cnt70_ch0", pc[0], 56);
        chk("cnt70_ch2", pc[2], 56);

        // num=0 disables ch0; num>den saturates ch1
        step(1'b0, 1'b1, 0, 0, 5, 1'b0);
        idle(16);
        step(1'b0, 1'b1, 1, 9, 4, 1'b0);
        idle(16);
        clr_pc();
        idle(50);
        chk("ch0_off", pc[0], 0);
        chk("ch1_full", pc[1], 50);

        // Out-of-range channel write is ignored
        step(1'b0, 1'b1, 3, 5, 6, 1'b0);
        chk("bad_ch_locked", int'(locked), 1);
        idle(20);

        // Reset during a lock count, together with a write
        step(1'b0, 1'b1, 0, 7, 9, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 0, 7, 9, 1'b0);
        chk("rst_wr_locked", int'(locked), 0);
        idle(16);
        clr_pc();
        idle(25);
        chk("rst_wins_ch0", pc[0], 20);
        chk("rst_wins_ch1", pc[1], 5);

`ifdef CEGEN_SYNC_EN
        // Sync re-aligns phase without dropping lock
        idle(3);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1);
        chk("sync_ce", int'(ce_o), 0);
        chk("sync_locked", int'(locked), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            seen += (int'(ce_o[0]) == pat[i % 5]) ? 1 : 0;
        end
        chk("sync_pattern", seen, 10);
`endif

        // Random reprogramming, resets and syncs
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1)
                step(1'b1, 1'($urandom_range(0, 1)), 0, 3, 4, 1'b0);
            else if (r < 6)
                step(1'b0, 1'b1, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 12)), 1'b0);
            else if (r < 9)
                step(1'b0, 1'b0, 0, 0, 0, 1'b1);
            else
                idle(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
